saturn_alru_seq: RTL and testbench

- Control-side initiator for saturn_alru: accepts one decoded register-field operation and drives the alru control strobes in the required order.
- Order: latch ALU operand registers, then write back to destination and/or op1, or sample the condition for test-only ops.
- Converts the Saturn field code plus the current P value into left/right nibble masks.
- Sits between the instruction decoder and saturn_alru.

---
 rtl/saturn_pkg.sv | 27 ++
 rtl/saturn_field_mask.sv | 31 +++
 rtl/saturn_alru_seq.sv | 134 +++++++++++++
 tb/tb_saturn_alru_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/saturn_pkg.sv
// Shared Saturn definitions: field codes, sequencer state encoding and
// register class constants used by the alru and its control side.
package saturn_pkg;

  localparam logic [3:0] FLD_P  = 4'h0;
  localparam logic [3:0] FLD_WP = 4'h1;
  localparam logic [3:0] FLD_XS = 4'h2;
  localparam logic [3:0] FLD_X  = 4'h3;
  localparam logic [3:0] FLD_S  = 4'h4;
  localparam logic [3:0] FLD_M  = 4'h5;
  localparam logic [3:0] FLD_B  = 4'h6;
  localparam logic [3:0] FLD_W  = 4'h7;
  localparam logic [3:0] FLD_A  = 4'hF;

  localparam logic [1:0] RC_WORK    = 2'd0;
  localparam logic [1:0] RC_SCRATCH = 2'd1;
  localparam logic [1:0] RC_PTR     = 2'd2;
  localparam logic [1:0] RC_SPECIAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/saturn_field_mask.sv
// Maps a Saturn field code and P value to the left/right nibble bounds;
// codes 8..E have no meaning and are flagged illegal.
module saturn_field_mask
  import saturn_pkg::*;
(
  input  logic [3:0] field_i,
  input  logic [3:0] p_i,
  output logic [3:0] left_o,
  output logic [3:0] right_o,
  output logic       illegal_o
);

  always_comb begin
    left_o    = 4'd0;
    right_o   = 4'd0;
    illegal_o = 1'b0;
    case (field_i)
      FLD_P:   begin left_o = p_i;   right_o = p_i;   end
      FLD_WP:  begin left_o = p_i;   right_o = 4'd0;  end
      FLD_XS:  begin left_o = 4'd2;  right_o = 4'd2;  end
      FLD_X:   begin left_o = 4'd2;  right_o = 4'd0;  end
      FLD_S:   begin left_o = 4'd15; right_o = 4'd15; end
      FLD_M:   begin left_o = 4'd14; right_o = 4'd3;  end
      FLD_B:   begin left_o = 4'd1;  right_o = 4'd0;  end
      FLD_W:   begin left_o = 4'd15; right_o = 4'd0;  end
      FLD_A:   begin left_o = 4'd4;  right_o = 4'd0;  end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/saturn_alru_seq.sv
// Control-side sequencer for saturn_alru: latches operands, then issues the
// writeback strobes (or samples the condition for test-only operations).
module saturn_alru_seq
  import saturn_pkg::*;
#(
  parameter int LATCH_CYCLES = 1
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       start_in,
  input  logic [3:0] field_in,
  input  logic [3:0] p_in,
  input  logic [3:0] alu_op_in,
  input  logic [1:0] op1_type_reg_in,
  input  logic [2:0] op1_reg_in,
  input  logic [1:0] dst_type_reg_in,
  input  logic [3:0] dst_reg_in,
  input  logic       decimal_in,
  input  logic       forced_carry_in,
  input  logic       wb_dst_in,
  input  logic       wb_op1_in,
  input  logic       condition_true_in,
  output logic       latch_alu_regs_o,
  output logic       write_dst_o,
  output logic       write_op1_o,
  output logic [3:0] left_mask_o,
  output logic [3:0] right_mask_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] op1_type_reg_o,
  output logic [2:0] op1_reg_o,
  output logic [1:0] dst_type_reg_o,
  output logic [3:0] dst_reg_o,
  output logic       decimal_o,
  output logic       forced_carry_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       cond_o,
  output logic       field_err_o
);

  localparam logic [1:0] LAST_CNT = 2'(LATCH_CYCLES - 1);

  logic [3:0] mask_left, mask_right;
  logic       mask_illegal;

  saturn_field_mask u_field_mask (
    .field_i   (field_in),
    .p_i       (p_in),
    .left_o    (mask_left),
    .right_o   (mask_right),
    .illegal_o (mask_illegal)
  );

  seq_state_e state_q;
  logic [1:0] cnt_q, cnt_d;
  logic       wb_dst_q, wb_op1_q;

  assign cnt_d = cnt_q + 2'd1;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 2'd0;
      wb_dst_q         <= 1'b0;
      wb_op1_q         <= 1'b0;
      latch_alu_regs_o <= 1'b0;
      write_dst_o      <= 1'b0;
      write_op1_o      <= 1'b0;
      left_mask_o      <= 4'd0;
      right_mask_o     <= 4'd0;
      alu_op_o         <= 4'd0;
      op1_type_reg_o   <= 2'd0;
      op1_reg_o        <= 3'd0;
      dst_type_reg_o   <= 2'd0;
      dst_reg_o        <= 4'd0;
      decimal_o        <= 1'b0;
      forced_carry_o   <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      cond_o           <= 1'b0;
      field_err_o      <= 1'b0;
    end else begin
      field_err_o <= 1'b0;
      done_o      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // An illegal field is rejected without touching the captured operands.
          if (start_in && mask_illegal) begin
            field_err_o <= 1'b1;
          end else if (start_in) begin
            left_mask_o      <= mask_left;
            right_mask_o     <= mask_right;
            alu_op_o         <= alu_op_in;
            op1_type_reg_o   <= op1_type_reg_in;
            op1_reg_o        <= op1_reg_in;
            dst_type_reg_o   <= dst_type_reg_in;
            dst_reg_o        <= dst_reg_in;
            decimal_o        <= decimal_in;
            forced_carry_o   <= forced_carry_in;
            wb_dst_q         <= wb_dst_in;
            wb_op1_q         <= wb_op1_in;
            cnt_q            <= 2'd0;
            busy_o           <= 1'b1;
            latch_alu_regs_o <= 1'b1;
            state_q          <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (cnt_q == LAST_CNT) begin
            latch_alu_regs_o <= 1'b0;
            write_dst_o      <= wb_dst_q;
            write_op1_o      <= wb_op1_q;
            cnt_q            <= 2'd0;
            state_q          <= ST_WRITE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_WRITE: begin
          write_dst_o <= 1'b0;
          write_op1_o <= 1'b0;
          // Only test-only ops update the condition; it is held otherwise.
          if (!wb_dst_q && !wb_op1_q) cond_o <= condition_true_in;
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_alru_seq.sv
// Directed bench for saturn_alru_seq: table of single operations on a
// LATCH_CYCLES=1 instance plus reset and back-to-back cases on LATCH_CYCLES=3.
module tb_saturn_alru_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [3:0] field_in = 4'd0, p_in = 4'd0, alu_op_in = 4'd0, dst_reg_in = 4'd0;
  logic [1:0] op1_type_in = 2'd0, dst_type_in = 2'd0;
  logic [2:0] op1_reg_in = 3'd0;
  logic       decimal_in = 1'b0, fcarry_in = 1'b0;
  logic       wbd_in = 1'b0, wbo_in = 1'b0, cond_in = 1'b0;

  logic       o_latch, o_wd, o_wo, o_dec, o_fc, o_busy, o_done, o_cond, o_err;
  logic [3:0] o_left, o_right, o_alu, o_dreg;
  logic [1:0] o_op1t, o_dstt;
  logic [2:0] o_op1r;

  logic       t_latch, t_wd, t_wo, t_dec, t_fc, t_busy, t_done, t_cond, t_err;
  logic [3:0] t_left, t_right, t_alu, t_dreg;
  logic [1:0] t_op1t, t_dstt;
  logic [2:0] t_op1r;

  always #5 clk = ~clk;

  saturn_alru_seq #(.LATCH_CYCLES(1)) dut1 (
    .clk_in(clk), .reset_in(rst), .start_in(start1), .field_in(field_in), .p_in(p_in),
    .alu_op_in(alu_op_in), .op1_type_reg_in(op1_type_in), .op1_reg_in(op1_reg_in),
    .dst_type_reg_in(dst_type_in), .dst_reg_in(dst_reg_in), .decimal_in(decimal_in),
    .forced_carry_in(fcarry_in), .wb_dst_in(wbd_in), .wb_op1_in(wbo_in),
    .condition_true_in(cond_in), .latch_alu_regs_o(o_latch), .write_dst_o(o_wd),
    .write_op1_o(o_wo), .left_mask_o(o_left), .right_mask_o(o_right), .alu_op_o(o_alu),
    .op1_type_reg_o(o_op1t), .op1_reg_o(o_op1r), .dst_type_reg_o(o_dstt),
    .dst_reg_o(o_dreg), .decimal_o(o_dec), .forced_carry_o(o_fc), .busy_o(o_busy),
    .done_o(o_done), .cond_o(o_cond), .field_err_o(o_err)
  );

  saturn_alru_seq #(.LATCH_CYCLES(3)) dut3 (
    .clk_in(clk), .reset_in(rst), .start_in(start3), .field_in(field_in), .p_in(p_in),
    .alu_op_in(alu_op_in), .op1_type_reg_in(op1_type_in), .op1_reg_in(op1_reg_in),
    .dst_type_reg_in(dst_type_in), .dst_reg_in(dst_reg_in), .decimal_in(decimal_in),
    .forced_carry_in(fcarry_in), .wb_dst_in(wbd_in), .wb_op1_in(wbo_in),
    .condition_true_in(cond_in), .latch_alu_regs_o(t_latch), .write_dst_o(t_wd),
    .write_op1_o(t_wo), .left_mask_o(t_left), .right_mask_o(t_right), .alu_op_o(t_alu),
    .op1_type_reg_o(t_op1t), .op1_reg_o(t_op1r), .dst_type_reg_o(t_dstt),
    .dst_reg_o(t_dreg), .decimal_o(t_dec), .forced_carry_o(t_fc), .busy_o(t_busy),
    .done_o(t_done), .cond_o(t_cond), .field_err_o(t_err)
  );

  typedef struct {
    logic [3:0] field;
    logic [3:0] p;
    logic       wbd;
    logic       wbo;
    logic       cond;
    logic [3:0] el;
    logic [3:0] er;
    logic       err;
  } vec_t;

  vec_t tbl [12];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_cond = 1'b0;
  logic [3:0] last_alu = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                field  p     wbd   wbo   cond  left   right  err
    tbl[0]  = '{4'h7, 4'd0,  1'b1, 1'b0, 1'b0, 4'd15, 4'd0,  1'b0};
    tbl[1]  = '{4'h0, 4'd5,  1'b1, 1'b0, 1'b0, 4'd5,  4'd5,  1'b0};
    tbl[2]  = '{4'h1, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0};
    tbl[3]  = '{4'h1, 4'd15, 1'b1, 1'b0, 1'b0, 4'd15, 4'd0,  1'b0};
    tbl[4]  = '{4'h3, 4'd0,  1'b0, 1'b0, 1'b1, 4'd2,  4'd0,  1'b0};
    tbl[5]  = '{4'h4, 4'd0,  1'b0, 1'b0, 1'b0, 4'd15, 4'd15, 1'b0};
    tbl[6]  = '{4'hF, 4'd0,  1'b1, 1'b1, 1'b0, 4'd4,  4'd0,  1'b0};
    tbl[7]  = '{4'h8, 4'd3,  1'b1, 1'b0, 1'b0, 4'd4,  4'd0,  1'b1};
    tbl[8]  = '{4'h5, 4'd0,  1'b1, 1'b0, 1'b1, 4'd14, 4'd3,  1'b0};
    tbl[9]  = '{4'h2, 4'd9,  1'b0, 1'b1, 1'b1, 4'd2,  4'd2,  1'b0};
    tbl[10] = '{4'hE, 4'd7,  1'b1, 1'b1, 1'b0, 4'd2,  4'd2,  1'b1};
    tbl[11] = '{4'h6, 4'd0,  1'b0, 1'b0, 1'b1, 4'd1,  4'd0,  1'b0};

    step();
    step();
    chk("rst_latch", o_latch, 0);
    chk("rst_busy",  o_busy,  0);
    chk("rst_masks", {o_left, o_right}, 0);
    chk("rst_misc",  {o_done, o_cond, o_err, o_wd, o_wo, o_alu}, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      field_in    = tbl[i].field;
      p_in        = tbl[i].p;
      wbd_in      = tbl[i].wbd;
      wbo_in      = tbl[i].wbo;
      alu_op_in   = 4'(i);
      decimal_in  = i[0];
      cond_in     = ~tbl[i].cond;
      start1      = 1'b1;
      step();
      start1      = 1'b0;
      if (tbl[i].err) begin
        chk("ill_err",   o_err,   1);
        chk("ill_busy",  {o_busy, o_latch, o_wd, o_wo}, 0);
        chk("ill_masks", {o_left, o_right}, {tbl[i].el, tbl[i].er});
        chk("ill_aluop", o_alu, last_alu);
        step();
        chk("ill_pulse", {o_err, o_busy, o_latch, o_wd, o_wo}, 0);
      end else begin
        last_alu = 4'(i);
        chk("lat_latch", {o_latch, o_busy, o_err}, 3'b110);
        chk("lat_masks", {o_left, o_right}, {tbl[i].el, tbl[i].er});
        chk("lat_fields", {o_alu, o_dec}, {4'(i), i[0]});
        chk("lat_nowr",  {o_wd, o_wo}, 0);
        step();
        cond_in = tbl[i].cond;
        chk("wr_latch",  o_latch, 0);
        chk("wr_strobes", {o_wd, o_wo}, {tbl[i].wbd, tbl[i].wbo});
        chk("wr_busy",   {o_busy, o_done}, 2'b10);
        step();
        if (!tbl[i].wbd && !tbl[i].wbo) exp_cond = tbl[i].cond;
        chk("dn_done",  {o_done, o_busy, o_wd, o_wo, o_latch}, 5'b10000);
        chk("dn_cond",  o_cond, exp_cond);
        step();
        chk("idle_done", {o_done, o_busy}, 0);
      end
    end

    // Reset asserted while the slow instance is latching.
    field_in = 4'h7; wbd_in = 1'b1; wbo_in = 1'b0; alu_op_in = 4'hA;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    chk("r_latch_on", {t_latch, t_busy}, 2'b11);
    step();
    rst = 1'b1;
    #1;
    chk("r_drop", {t_latch, t_busy, t_wd, t_wo, t_done}, 0);
    chk("r_clear", {t_left, t_right, t_alu}, 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("r_nowrite", {t_wd, t_wo, t_latch, t_done}, 0);
    end

    // start held high: one accept every LATCH_CYCLES+3 = 6 cycles.
    field_in = 4'hF; wbd_in = 1'b1;
    start3 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      chk("bb_latch", t_latch, ((k % 6) < 3) ? 1 : 0);
      chk("bb_write", t_wd,    ((k % 6) == 3) ? 1 : 0);
      chk("bb_done",  t_done,  ((k % 6) == 4) ? 1 : 0);
      chk("bb_busy",  t_busy,  ((k % 6) < 4) ? 1 : 0);
    end
    start3 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
